// File: rtl/otter_wb_pkg.sv
// Purpose: shared types, sizes and helpers for the OTTER writeback arbiter.
//   XLEN/RF_AW/RF_DEPTH : register file geometry
//   wb_req_t            : one writeback request payload (dest address + data)
//   rr_next(g, n)       : round-robin successor of index g among n requesters
package otter_wb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned RF_DEPTH = 32;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  // Index after g, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return ((g + 1) >= n) ? 0 : (g + 1);
  endfunction

endpackage

// File: rtl/otter_rr_arbiter.sv
// Purpose: generic N-way round-robin arbiter with a registered rotating pointer.
// Ports:
//   i_clk, i_rst (async active-high)
//   i_valid      [N]  request vector
//   o_grant      [N]  one-hot grant (combinational, zero while in reset)
//   o_grant_any       some requester is granted this cycle
// The pointer moves past the granted index on every grant and holds otherwise.
module otter_rr_arbiter
  import otter_wb_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_valid,
  output logic [N-1:0] o_grant,
  output logic         o_grant_any
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_any;
  int unsigned   w_scan;

  // Search from the pointer, wrapping; first valid wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    w_scan  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_scan = 32'(r_ptr) + k;
      if (w_scan >= N) w_scan = w_scan - N;
      if (!w_any && i_valid[w_scan]) begin
        w_any           = 1'b1;
        w_grant[w_scan] = 1'b1;
        w_idx           = IW'(w_scan);
      end
    end
    // No handshake can complete while reset is held.
    if (i_rst) begin
      w_grant = '0;
      w_idx   = '0;
      w_any   = 1'b0;
    end
  end

  // Rotating priority pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= IW'(rr_next(32'(w_idx), N));
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_any = w_any;

endmodule

// File: rtl/otter_rf_wb_arbiter.sv
// Purpose: shares the register file write port among NUM_REQ writeback sources
//   using round-robin valid/ready arbitration and one registered output stage.
// Ports:
//   i_clk, i_rst (async active-high)
//   i_req_valid/o_req_ready [NUM_REQ]        per-source handshake (ready one-hot)
//   i_req_addr [NUM_REQ*AW], i_req_data [NUM_REQ*XLEN]  packed per-source payloads
//   o_w_en/o_w_addr/o_w_data                 register file write port (1-cycle latency)
//   i_rsv_en/i_rsv_addr                      reserve a destination at decode
//   i_chk_addr1/i_chk_addr2, o_hazard        source-operand busy check
// Config: define OTTER_WB_SCOREBOARD_EN to build the busy-register scoreboard;
//   otherwise the rsv/chk inputs are ignored and o_hazard is 0.
module otter_rf_wb_arbiter
  import otter_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*AW-1:0]   i_req_addr,
  input  logic [NUM_REQ*XLEN-1:0] i_req_data,
  output logic                    o_w_en,
  output logic [AW-1:0]           o_w_addr,
  output logic [XLEN-1:0]         o_w_data,
  input  logic                    i_rsv_en,
  input  logic [AW-1:0]           i_rsv_addr,
  input  logic [AW-1:0]           i_chk_addr1,
  input  logic [AW-1:0]           i_chk_addr2,
  output logic                    o_hazard
);

  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_any;
  logic [AW-1:0]      w_sel_addr;
  logic [XLEN-1:0]    w_sel_data;

  logic               r_w_en;
  logic [AW-1:0]      r_w_addr;
  logic [XLEN-1:0]    r_w_data;

  otter_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_req_valid),
    .o_grant     (w_grant),
    .o_grant_any (w_grant_any)
  );

  assign o_req_ready = w_grant;

  // One-hot payload mux of the granted requester.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = w_sel_addr | i_req_addr[i*AW +: AW];
        w_sel_data = w_sel_data | i_req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Write port stage; x0 writes complete the handshake but never enable the RF.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else if (w_grant_any) begin
      r_w_en   <= (w_sel_addr != '0);
      r_w_addr <= w_sel_addr;
      r_w_data <= w_sel_data;
    end else begin
      r_w_en   <= 1'b0;
    end
  end

  assign o_w_en   = r_w_en;
  assign o_w_addr = r_w_addr;
  assign o_w_data = r_w_data;

`ifdef OTTER_WB_SCOREBOARD_EN
  logic [RF_DEPTH-1:0] r_busy;
  logic [RF_DEPTH-1:0] w_busy_nxt;

  // Clear on commit first so a same-edge reservation of that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_w_en) w_busy_nxt[r_w_addr] = 1'b0;
    if (i_rsv_en) w_busy_nxt[i_rsv_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy-register vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_hazard = r_busy[i_chk_addr1] | r_busy[i_chk_addr2];
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{i_rsv_en, i_rsv_addr, i_chk_addr1, i_chk_addr2};
  assign o_hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_otter_rf_wb_arbiter.sv
// Directed bench for otter_rf_wb_arbiter (NUM_REQ=3). Inputs change #1 after
// posedge; outputs are checked #1 after that, away from the clock edge.
module tb_otter_rf_wb_arbiter;

`ifdef OTTER_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [14:0] addr;
  logic [95:0] data;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  chk1;
  logic [4:0]  chk2;
  logic        hazard;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  otter_rf_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .AW(5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .o_req_ready (ready),
    .i_req_addr  (addr),
    .i_req_data  (data),
    .o_w_en      (w_en),
    .o_w_addr    (w_addr),
    .o_w_data    (w_data),
    .i_rsv_en    (rsv_en),
    .i_rsv_addr  (rsv_addr),
    .i_chk_addr1 (chk1),
    .i_chk_addr2 (chk2),
    .o_hazard    (hazard)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to #1 after the next posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    addr[i*5 +: 5]  = a;
    data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; valid = 3'b111; addr = '0; data = '0;
    rsv_en = 1'b0; rsv_addr = '0; chk1 = '0; chk2 = '0;
    #12;
    chk("rst_ready", 64'(ready), 64'(3'b000));
    chk("rst_wen",   64'(w_en), 64'(0));
    chk("rst_waddr", 64'(w_addr), 64'(0));
    chk("rst_wdata", 64'(w_data), 64'(0));
    chk("rst_hazard", 64'(hazard), 64'(0));

    // Single source on requester 1.
    tick();
    valid = 3'b000; rst = 1'b0;
    tick();
    valid = 3'b010; set_req(1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 64'(ready), 64'(3'b010));
    tick();
    valid = 3'b000;
    #1;
    chk("single_wen",   64'(w_en), 64'(1));
    chk("single_waddr", 64'(w_addr), 64'(5));
    chk("single_wdata", 64'(w_data), 64'(32'hDEADBEEF));
    tick();
    chk("single_wen_off", 64'(w_en), 64'(0));

    // x0 drop on requester 2; pointer (now 2) advances to 0.
    valid = 3'b100; set_req(2, 5'd0, 32'h1234);
    #1 chk("x0_ready", 64'(ready), 64'(3'b100));
    tick();
    valid = 3'b000;
    #1 chk("x0_wen", 64'(w_en), 64'(0));

    // Fairness: all valid for 6 cycles -> grants 0,1,2,0,1,2.
    set_req(0, 5'd10, 32'hA0A0_0000);
    set_req(1, 5'd11, 32'hA1A1_1111);
    set_req(2, 5'd12, 32'hA2A2_2222);
    valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [2:0]  exp_g;
      logic [31:0] exp_d;
      exp_g = 3'(1 << (c % 3));
      exp_d = (c % 3 == 0) ? 32'hA0A0_0000 : (c % 3 == 1) ? 32'hA1A1_1111 : 32'hA2A2_2222;
      #1 chk($sformatf("rr_ready_%0d", c), 64'(ready), 64'(exp_g));
      tick();
      chk($sformatf("rr_wen_%0d", c),   64'(w_en), 64'(1));
      chk($sformatf("rr_waddr_%0d", c), 64'(w_addr), 64'(10 + (c % 3)));
      chk($sformatf("rr_wdata_%0d", c), 64'(w_data), 64'(exp_d));
    end
    valid = 3'b000;

    // Idle hold for 4 cycles.
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("idle_wen_%0d", c),   64'(w_en), 64'(0));
      chk($sformatf("idle_waddr_%0d", c), 64'(w_addr), 64'(12));
      chk($sformatf("idle_wdata_%0d", c), 64'(w_data), 64'(32'hA2A2_2222));
    end
    valid = 3'b111;
    #1 chk("idle_ptr_ready", 64'(ready), 64'(3'b001));

    // Reset mid-operation: requester 0 just granted, pointer is 1.
    tick();
    chk("mid_ready_pre", 64'(ready), 64'(3'b010));
    chk("mid_wen_pre",   64'(w_en), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_wen",   64'(w_en), 64'(0));
    chk("mid_rst_ready", 64'(ready), 64'(3'b000));
    chk("mid_rst_waddr", 64'(w_addr), 64'(0));
    tick();
    rst = 1'b0;
    #1 chk("mid_post_ready", 64'(ready), 64'(3'b001));
    tick();
    valid = 3'b000;

    // Scoreboard: reserve x7.
    set_req(0, 5'd7, 32'h7777_7777);
    rsv_en = 1'b1; rsv_addr = 5'd7; chk1 = 5'd7; chk2 = 5'd0;
    #1 chk("sb_pre_hazard", 64'(hazard), 64'(0));
    tick();
    rsv_en = 1'b0;
    #1 chk("sb_rsv_hazard", 64'(hazard), 64'(SB));
    chk1 = 5'd0; chk2 = 5'd7;
    #1 chk("sb_rs2_hazard", 64'(hazard), 64'(SB));
    chk2 = 5'd0;
    #1 chk("sb_x0_hazard", 64'(hazard), 64'(0));
    chk1 = 5'd7;
    // Writeback to x7 clears busy at the commit edge.
    valid = 3'b001;
    #1 chk("sb_wb_ready", 64'(ready), 64'(3'b001));
    tick();
    valid = 3'b000;
    #1;
    chk("sb_wb_wen",    64'(w_en), 64'(1));
    chk("sb_wb_hazard", 64'(hazard), 64'(SB));
    tick();
    chk("sb_clr_hazard", 64'(hazard), 64'(0));

    // Reserve and clear x7 at the same edge: set wins.
    rsv_en = 1'b1;
    tick();
    rsv_en = 1'b0;
    valid = 3'b001;
    tick();
    valid = 3'b000;
    rsv_en = 1'b1;
    #1 chk("sb_both_wen", 64'(w_en), 64'(1));
    tick();
    rsv_en = 1'b0;
    #1 chk("sb_both_hazard", 64'(hazard), 64'(SB));
    tick();
    chk("sb_both_hold", 64'(hazard), 64'(SB));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
